scroll_digit_feeder: RTL and testbench

//  Producer end of the scroller digit interface. Accepts ASCII bytes (e.g. from a UART receiver) and collects up to 3 decimal digits.

---
 rtl/scroll_digit_feeder_pkg.sv | 22 ++
 rtl/scroll_digit_feeder_if.sv | 22 ++
 rtl/scroll_digit_feeder_ascii_digit_class.sv | 25 ++
 rtl/scroll_digit_feeder.sv | 155 +++++++++++++++
 tb/tb_scroll_digit_feeder.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scroll_digit_feeder_pkg.sv
// Shared constants for the scroller digit feeder: blank code, ASCII
// character values, FSM state encoding and the fixed digits-per-burst.
package scroll_pkg;

  localparam logic [3:0] BLK_CODE = 4'hF;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_C_UP = 8'h43;
  localparam logic [7:0] CH_C_LO = 8'h63;

  // The scroller shows exactly three digits; not meant to be overridden.
  localparam int NDIG = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/scroll_digit_feeder_if.sv
// Byte-source / scroller-side bundle of the digit feeder.
// master: the ASCII byte source (drives iASCII/iVALID, observes the rest).
// slave : the feeder itself.
interface scroll_digit_feeder_if;
  logic [7:0] iASCII;
  logic       iVALID;
  logic       oBUSY;
  logic       oRD;
  logic [3:0] oDEC;
  logic       oCLEAN;
  logic [7:0] oERRCNT;

  modport master (
    output iASCII, iVALID,
    input  oBUSY, oRD, oDEC, oCLEAN, oERRCNT
  );

  modport slave (
    input  iASCII, iVALID,
    output oBUSY, oRD, oDEC, oCLEAN, oERRCNT
  );
endinterface

// File: rtl/scroll_digit_feeder_ascii_digit_class.sv
// Combinational classifier for a received ASCII byte: decimal digit,
// carriage return, or clear command ('C'/'c'). digit is only meaningful
// when is_digit is high.
module ascii_digit_class
  import scroll_pkg::*;
(
  input  logic [7:0] ascii,
  output logic       is_digit,
  output logic       is_cr,
  output logic       is_clr,
  output logic [3:0] digit
);

  logic [7:0] offs;

  // Decode the character class and the digit value.
  always_comb begin
    offs     = ascii - CH_0;
    is_digit = (ascii >= CH_0) && (ascii <= CH_9);
    is_cr    = (ascii == CH_CR);
    is_clr   = (ascii == CH_C_UP) || (ascii == CH_C_LO);
    digit    = is_digit ? offs[3:0] : BLK_CODE;
  end

endmodule

// File: rtl/scroll_digit_feeder.sv
// Producer end of the scroller digit interface. Collects up to three
// decimal digits from an ASCII byte stream and emits them as a three-beat
// RD/DEC burst; 'C'/'c' raises a one-cycle CLEAN pulse.
// Optional feature macro: SCROLL_FEED_ERRCNT_EN (rejected-character count
// on oERRCNT; tied to zero when undefined).
module scroll_digit_feeder
  import scroll_pkg::*;
#(
  parameter int         GAP_CYCLES = 2,
  parameter logic [3:0] BLK        = BLK_CODE
) (
  input  logic                  clk,
  input  logic                  rst,
  scroll_digit_feeder_if.slave  bus
);

  localparam int             GW       = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [1:0]     LAST     = 2'(NDIG - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [NDIG-1:0][3:0]      buf_q, buf_d;
  logic [1:0]                beat_q, beat_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [3:0]                dec_q, dec_d;
  logic                      clean_q, clean_d;

  logic                      is_digit, is_cr, is_clr;
  logic [3:0]                digit;
  logic                      take;

  ascii_digit_class u_class (
    .ascii    (bus.iASCII),
    .is_digit (is_digit),
    .is_cr    (is_cr),
    .is_clr   (is_clr),
    .digit    (digit)
  );

  // Characters are only accepted while idle; anything else is dropped.
  assign take = bus.iVALID && (state_q == IDLE);

  // Next-state, buffer fill and burst sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    dec_d   = BLK;
    clean_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          if (is_digit) begin
            buf_d[cnt_q] = digit;
            cnt_d        = cnt_q + 2'd1;
            // Third digit starts the burst without waiting for CR.
            if (cnt_q == LAST) begin
              state_d = SEND;
              beat_d  = 2'd0;
            end
          end else if (is_cr) begin
            if (cnt_q != 2'd0) begin
              for (int i = 0; i < NDIG; i++)
                if (2'(i) >= cnt_q) buf_d[i] = BLK;
              state_d = SEND;
              beat_d  = 2'd0;
            end
          end else if (is_clr) begin
            clean_d = 1'b1;
            cnt_d   = 2'd0;
            for (int i = 0; i < NDIG; i++) buf_d[i] = BLK;
          end
        end
      end
      SEND: begin
        // DEC trails RD by one cycle: the scroller registers iRD first.
        dec_d = buf_q[beat_q];
        if (beat_q == LAST) begin
          state_d = GAP;
          gap_d   = '0;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          for (int i = 0; i < NDIG; i++) buf_d[i] = BLK;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, buffer and registered outputs; reset aborts any burst at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      buf_q   <= {NDIG{BLK}};
      beat_q  <= 2'd0;
      gap_q   <= '0;
      dec_q   <= BLK;
      clean_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      dec_q   <= dec_d;
      clean_q <= clean_d;
    end
  end

  assign bus.oBUSY  = (state_q != IDLE);
  assign bus.oRD    = (state_q == SEND);
  assign bus.oDEC   = dec_q;
  assign bus.oCLEAN = clean_q;

`ifdef SCROLL_FEED_ERRCNT_EN
  logic [7:0] err_q, err_d;

  // Count ignored and busy-dropped characters; a clear command zeroes it.
  always_comb begin
    err_d = err_q;
    if (bus.iVALID) begin
      if (state_q != IDLE) begin
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end else if (is_clr) begin
        err_d = 8'h00;
      end else if (!is_digit && !is_cr) begin
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 8'h00;
    else      err_q <= err_d;
  end

  assign bus.oERRCNT = err_q;
`else
  assign bus.oERRCNT = 8'h00;
`endif

endmodule

// File: tb/tb_scroll_digit_feeder.sv
// Directed bench for scroll_digit_feeder, paired with a small model of the
// scroller's write port (registers iRD, stores DEC on each registered beat).
module tb_scroll_digit_feeder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  scroll_digit_feeder_if bus();

  scroll_digit_feeder #(.GAP_CYCLES(2), .BLK(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scroller write-port model.
  logic       sc_rd;
  logic [1:0] sc_beat;
  logic [3:0] sc_dig [3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_rd   <= 1'b0;
      sc_beat <= 2'd0;
      for (int k = 0; k < 3; k++) sc_dig[k] <= 4'hF;
    end else begin
      sc_rd <= bus.oRD;
      if (sc_rd) begin
        if (sc_beat < 2'd3) begin
          sc_dig[sc_beat] <= bus.oDEC;
          sc_beat         <= sc_beat + 2'd1;
        end
      end else begin
        sc_beat <= 2'd0;
      end
    end
  end

  // One-cycle iVALID pulse; returns on the negedge after the sampling edge.
  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    bus.iASCII = c;
    bus.iVALID = 1'b1;
    @(negedge clk);
    bus.iVALID = 1'b0;
    bus.iASCII = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.iASCII = 8'h00;
    bus.iVALID = 1'b0;
    #12;
    n_cmp++;
    if (bus.oRD !== 1'b0 || bus.oDEC !== 4'hF || bus.oCLEAN !== 1'b0 ||
        bus.oBUSY !== 1'b0 || bus.oERRCNT !== 8'h00) begin
      n_err++;
      $display("FAIL reset rd=%b dec=%h clean=%b busy=%b err=%h want 0 F 0 0 00",
               bus.oRD, bus.oDEC, bus.oCLEAN, bus.oBUSY, bus.oERRCNT);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_three_digits;
    logic [3:0] ed [5];
    logic       er [5];
    ed = '{4'hF, 4'h1, 4'h2, 4'h3, 4'hF};
    er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    send_char("1"); repeat (3) @(negedge clk);
    send_char("2"); repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.oRD !== 1'b0) begin
      n_err++; $display("FAIL t1_no_early_rd rd=%b want 0", bus.oRD);
    end
    send_char("3");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (bus.oRD !== er[i] || bus.oDEC !== ed[i] || bus.oBUSY !== 1'b1) begin
        n_err++;
        $display("FAIL t1_beat%0d rd=%b dec=%h busy=%b want rd=%b dec=%h busy=1",
                 i, bus.oRD, bus.oDEC, bus.oBUSY, er[i], ed[i]);
      end
    end
    n_cmp++;
    if (sc_dig[0] !== 4'h1 || sc_dig[1] !== 4'h2 || sc_dig[2] !== 4'h3) begin
      n_err++;
      $display("FAIL t1_scroller got %h%h%h want 123", sc_dig[0], sc_dig[1], sc_dig[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_cr;
    logic [3:0] ed [5];
    logic       er [5];
    logic       seen;
    ed = '{4'hF, 4'h7, 4'hF, 4'hF, 4'hF};
    er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    send_char("7");
    send_char(8'h0D);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (bus.oRD !== er[i] || bus.oDEC !== ed[i]) begin
        n_err++;
        $display("FAIL t2_beat%0d rd=%b dec=%h want rd=%b dec=%h",
                 i, bus.oRD, bus.oDEC, er[i], ed[i]);
      end
    end
    n_cmp++;
    if (sc_dig[0] !== 4'h7 || sc_dig[1] !== 4'hF || sc_dig[2] !== 4'hF) begin
      n_err++;
      $display("FAIL t2_scroller got %h%h%h want 7FF", sc_dig[0], sc_dig[1], sc_dig[2]);
    end
    @(negedge clk);
    send_char(8'h0D);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.oRD !== 1'b0 || bus.oBUSY !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL t2_lone_cr activity=%b want 0", seen);
    end
  endtask

  task automatic test_clear;
    logic [3:0] ed [5];
    ed = '{4'hF, 4'h5, 4'h6, 4'h7, 4'hF};
    send_char("4");
    send_char("c");
    n_cmp++;
    if (bus.oCLEAN !== 1'b1 || bus.oRD !== 1'b0) begin
      n_err++; $display("FAIL t3_clean_hi clean=%b rd=%b want 1 0", bus.oCLEAN, bus.oRD);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.oCLEAN !== 1'b0) begin
      n_err++; $display("FAIL t3_clean_lo clean=%b want 0", bus.oCLEAN);
    end
    send_char("5");
    send_char("6");
    send_char("7");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (bus.oDEC !== ed[i] || bus.oRD !== (i < 3)) begin
        n_err++;
        $display("FAIL t3_beat%0d rd=%b dec=%h want dec=%h", i, bus.oRD, bus.oDEC, ed[i]);
      end
    end
    n_cmp++;
    if (sc_dig[0] !== 4'h5 || sc_dig[1] !== 4'h6 || sc_dig[2] !== 4'h7) begin
      n_err++;
      $display("FAIL t3_scroller got %h%h%h want 567", sc_dig[0], sc_dig[1], sc_dig[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_drop;
    logic [3:0] ed [5];
    logic [3:0] ed2 [5];
    ed  = '{4'hF, 4'h1, 4'h2, 4'h3, 4'hF};
    ed2 = '{4'hF, 4'h4, 4'hF, 4'hF, 4'hF};
    send_char("1");
    send_char("2");
    send_char("3");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (bus.oDEC !== ed[i] || bus.oRD !== (i < 3) || bus.oBUSY !== 1'b1) begin
        n_err++;
        $display("FAIL t4_beat%0d rd=%b dec=%h busy=%b want dec=%h busy=1",
                 i, bus.oRD, bus.oDEC, bus.oBUSY, ed[i]);
      end
      if (i == 1) begin bus.iASCII = "8"; bus.iVALID = 1'b1; end
      if (i == 2) begin bus.iVALID = 1'b0; bus.iASCII = 8'h00; end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.oBUSY !== 1'b0 || bus.oRD !== 1'b0) begin
      n_err++; $display("FAIL t4_gap_end busy=%b rd=%b want 0 0", bus.oBUSY, bus.oRD);
    end
    n_cmp++;
    if (sc_dig[0] !== 4'h1 || sc_dig[1] !== 4'h2 || sc_dig[2] !== 4'h3) begin
      n_err++;
      $display("FAIL t4_scroller got %h%h%h want 123", sc_dig[0], sc_dig[1], sc_dig[2]);
    end
    // A leaked '8' would appear as the first digit here.
    send_char("4");
    send_char(8'h0D);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (bus.oDEC !== ed2[i] || bus.oRD !== (i < 3)) begin
        n_err++;
        $display("FAIL t4_next%0d rd=%b dec=%h want dec=%h", i, bus.oRD, bus.oDEC, ed2[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst;
    logic [3:0] ed [5];
    ed = '{4'hF, 4'h9, 4'hF, 4'hF, 4'hF};
    send_char("1");
    send_char("2");
    send_char("3");
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.oRD !== 1'b0 || bus.oDEC !== 4'hF || bus.oBUSY !== 1'b0 ||
        bus.oERRCNT !== 8'h00) begin
      n_err++;
      $display("FAIL t5_abort rd=%b dec=%h busy=%b err=%h want 0 F 0 00",
               bus.oRD, bus.oDEC, bus.oBUSY, bus.oERRCNT);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.oRD !== 1'b0 || bus.oBUSY !== 1'b0) begin
      n_err++; $display("FAIL t5_no_resume rd=%b busy=%b want 0 0", bus.oRD, bus.oBUSY);
    end
    send_char("9");
    send_char(8'h0D);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (bus.oDEC !== ed[i] || bus.oRD !== (i < 3)) begin
        n_err++;
        $display("FAIL t5_beat%0d rd=%b dec=%h want dec=%h", i, bus.oRD, bus.oDEC, ed[i]);
      end
    end
    n_cmp++;
    if (sc_dig[0] !== 4'h9 || sc_dig[1] !== 4'hF || sc_dig[2] !== 4'hF) begin
      n_err++;
      $display("FAIL t5_scroller got %h%h%h want 9FF", sc_dig[0], sc_dig[1], sc_dig[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_errcnt;
`ifdef SCROLL_FEED_ERRCNT_EN
    send_char("x");
    send_char("#");
    n_cmp++;
    if (bus.oERRCNT !== 8'd2) begin
      n_err++; $display("FAIL t6_idle_rej err=%0d want 2", bus.oERRCNT);
    end
    send_char("5");
    send_char("6");
    send_char("7");
    @(negedge clk);
    bus.iASCII = "1"; bus.iVALID = 1'b1;
    @(negedge clk);
    bus.iVALID = 1'b0; bus.iASCII = 8'h00;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.oERRCNT !== 8'd3 || bus.oBUSY !== 1'b0) begin
      n_err++; $display("FAIL t6_busy_rej err=%0d busy=%b want 3 0", bus.oERRCNT, bus.oBUSY);
    end
    send_char("C");
    n_cmp++;
    if (bus.oERRCNT !== 8'd0 || bus.oCLEAN !== 1'b1) begin
      n_err++; $display("FAIL t6_clear err=%0d clean=%b want 0 1", bus.oERRCNT, bus.oCLEAN);
    end
`else
    send_char("x");
    n_cmp++;
    if (bus.oERRCNT !== 8'h00 || bus.oBUSY !== 1'b0) begin
      n_err++; $display("FAIL t6_tied err=%h busy=%b want 00 0", bus.oERRCNT, bus.oBUSY);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_three_digits();
    test_cr();
    test_clear();
    test_busy_drop();
    test_reset_mid_burst();
    test_errcnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not complete");
    $fatal(1);
  end

endmodule
